weight_loader: RTL and testbench

- Write-side counterpart of the weight ROM. Accepts a byte stream with a valid/ready handshake and assembles the bytes into dataWidth-bit weights.
- Drives a synchronous memory write port (wen/waddr/wdata) at sequential addresses 0..memSize-1.
- Used to load or refresh the weights of one neuron layer at run time instead of loading them at elaboration.
- Reports busy, done and early-termination error status to the layer controller.

---
 rtl/weight_loader.sv | 158 +++++++++++++++
 tb/tb_weight_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
//   Write-side counterpart of the weight ROM. It takes a byte stream over a
//   valid/ready handshake and packs the bytes MSB-first into dataWidth-bit
//   weights. Each finished weight is written to a synchronous memory port at
//   addresses 0..memSize-1. Busy, done and early-termination error status go
//   back to the layer controller.
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   start     one-cycle pulse, begins a load (IDLE or DONE)
//   abort     cancels the load in progress, returns to IDLE
//   in_valid  stream byte valid
//   in_data   stream byte, first byte of a word is its MSB
//   in_last   marks the final byte the source will send
//   in_ready  loader accepts a byte (registered, high in LOAD)
//   wen       one-cycle write strobe per completed word
//   waddr     write address (holds when wen=0)
//   wdata     write data (holds when wen=0)
//   busy      high in LOAD
//   done      high in DONE
//   err       load ended by an early in_last, valid while done=1
// ---------------------------------------------------------------------------
module weight_loader #(
    parameter int memSize   = 784,
    parameter int addrWidth = 10,
    parameter int dataWidth = 16,
    parameter int byteWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [byteWidth-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 wen,
    output logic [addrWidth-1:0] waddr,
    output logic [dataWidth-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int BPW = dataWidth / byteWidth;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t               state;
    logic [BCW-1:0]       bcnt;
    logic [addrWidth-1:0] wcnt;
    logic [dataWidth-1:0] asm_p0;
    logic [dataWidth-1:0] asm_nxt;
    logic                 xfer;
    logic                 word_end;
    logic                 last_word;

    // in_ready is only high in LOAD, so a transfer implies state==LOAD.
    assign xfer      = in_valid & in_ready;
    // Shifting left by one byte pushes the oldest byte out, so after BPW
    // transfers no byte of an earlier (aborted or reset) word survives.
    assign asm_nxt   = (asm_p0 << byteWidth) | dataWidth'(in_data);
    assign word_end  = (bcnt == BCW'(BPW - 1));
    assign last_word = (wcnt == addrWidth'(memSize - 1));

    // Assembly register: pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && xfer && !abort) begin
            asm_p0 <= asm_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wen      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            bcnt     <= '0;
            wcnt     <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        bcnt     <= '0;
                        wcnt     <= '0;
                        err      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        bcnt     <= '0;
                    end else if (xfer) begin
                        if (word_end) begin
                            bcnt  <= '0;
                            wen   <= 1'b1;
                            waddr <= wcnt;
                            wdata <= asm_nxt;
                            wcnt  <= wcnt + 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                        // The final word ends the load cleanly whatever in_last
                        // says. in_last anywhere else ends it early: a word it
                        // completes is still written, a partial word is dropped.
                        if (word_end && last_word) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (in_last) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            err      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        bcnt     <= '0;
                        wcnt     <= '0;
                        err      <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

    localparam int MEMSZ = 4;
    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int BPW   = DW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;

    weight_loader #(
        .memSize  (MEMSZ),
        .addrWidth(AW),
        .dataWidth(DW),
        .byteWidth(BW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_last (in_last),
        .in_ready(in_ready),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // mode: 0 idle, 1 loading, 2 finished
    int          m_mode  = 0;
    int          m_words = 0;
    bit          m_err   = 0;
    logic [7:0]  m_bytes[$];
    bit          e_wen   = 0;
    int          e_waddr = 0;
    int          e_wdata = 0;

    task automatic fresh_load();
        m_mode  = 1;
        m_words = 0;
        m_err   = 0;
        m_bytes.delete();
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_words = 0; m_err = 0; m_bytes.delete();
            e_wen = 0; e_waddr = 0; e_wdata = 0;
        end else begin
            e_wen = 0;
            if (m_mode == 0) begin
                if (start) fresh_load();
            end else if (m_mode == 1) begin
                if (abort) begin
                    m_mode = 0;
                    m_bytes.delete();
                end else if (in_valid) begin
                    m_bytes.push_back(in_data);
                    if (m_bytes.size() == BPW) begin
                        int w = 0;
                        foreach (m_bytes[k]) w = (w << BW) | int'(m_bytes[k]);
                        e_wen   = 1;
                        e_waddr = m_words;
                        e_wdata = w & 32'hFFFF;
                        m_words++;
                        m_bytes.delete();
                        if (m_words == MEMSZ) m_mode = 2;
                        else if (in_last) begin m_mode = 2; m_err = 1; end
                    end else if (in_last) begin
                        m_mode = 2;
                        m_err  = 1;
                    end
                end
            end else begin
                if (abort) m_mode = 0;
                else if (start) fresh_load();
            end
        end
        #1;
        chk("in_ready", in_ready, 32'(m_mode == 1));
        chk("busy",     busy,     32'(m_mode == 1));
        chk("done",     done,     32'(m_mode == 2));
        chk("err",      err,      32'(m_err));
        chk("wen",      wen,      32'(e_wen));
        chk("waddr",    waddr,    e_waddr);
        chk("wdata",    wdata,    e_wdata);
    end

    // ---------------- write capture for literal checks ----------------
    logic [DW-1:0] mem[MEMSZ];
    int            nwr      = 0;
    bit            wen_done = 0;

    always @(posedge clk) begin
        #1;
        if (wen) begin
            mem[waddr] = wdata;
            nwr++;
            wen_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic s, input logic a);
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; start = s; abort = a;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMSZ; i++) mem[i] = 16'hDEAD;
    endtask

    logic [7:0] b1[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] b2[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

    initial begin
        int n0;
        rst = 1; start = 0; abort = 0; in_valid = 0; in_data = 0; in_last = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_state", {in_ready, wen, busy, done, err}, 0);
        rst = 0;

        // Back-to-back full load
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive(1, b1[i], i == 7, 0, 0);
        idle(2);
        chk("t1_nwr", nwr - n0, 4);
        chk("t1_m0", mem[0], 16'h1234);
        chk("t1_m1", mem[1], 16'h5678);
        chk("t1_m2", mem[2], 16'h9ABC);
        chk("t1_m3", mem[3], 16'hDEF0);
        chk("t1_done_with_wen", wen_done, 1);
        chk("t1_status", {done, err, in_ready}, 3'b100);

        // Toggling valid
        clear_mem();
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, b1[i], i == 7, 0, 0);
            drive(0, 8'hFF, 0, 0, 0);
        end
        idle(1);
        chk("t2_nwr", nwr - n0, 4);
        chk("t2_m0", mem[0], 16'h1234);
        chk("t2_m3", mem[3], 16'hDEF0);

        // Early in_last on 5th byte
        clear_mem();
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, b2[i], i == 4, 0, 0);
        idle(2);
        chk("t3_nwr", nwr - n0, 2);
        chk("t3_m1", mem[1], 16'hC3D4);
        chk("t3_m2", mem[2], 16'hDEAD);
        chk("t3_status", {done, err}, 2'b11);

        // Abort simultaneous with a word-completing byte, then abort after 3 bytes
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        drive(1, 8'h11, 0, 0, 0);
        drive(1, 8'h22, 0, 0, 1);
        idle(2);
        chk("t4_abort_prio", nwr - n0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, b1[i], 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        idle(2);
        chk("t4_nwr", nwr - n0, 1);
        chk("t4_idle", {in_ready, busy, done}, 0);
        clear_mem();
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive(1, b2[i], 0, 0, 0);
        idle(2);
        chk("t4_reload_nwr", nwr - n0, 4);
        chk("t4_reload_m0", mem[0], 16'hA1B2);
        chk("t4_reload_m3", mem[3], 16'h0718);

        // Reset mid-word
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, b1[i], 0, 0, 0);
        @(negedge clk); rst = 1; in_valid = 0;
        repeat (2) @(negedge clk);
        chk("t5_rst_ctl", {in_ready, wen, busy, done, err}, 0);
        chk("t5_rst_data", {waddr, wdata}, 0);
        rst = 0;
        clear_mem();
        n0 = nwr;
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive(1, b2[i], 0, 0, 0);
        idle(2);
        chk("t5_nwr", nwr - n0, 4);
        chk("t5_m0", mem[0], 16'hA1B2);

        // Bytes in DONE and IDLE are ignored; start during LOAD ignored
        n0 = nwr;
        for (int i = 0; i < 3; i++) drive(1, 8'h55, 0, 0, 0);
        chk("t6_done_ign", nwr - n0, 0);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 8'h66, 1, 0, 0);
        chk("t6_idle_ign", {nwr - n0, 31'(in_ready)}, 0);
        clear_mem();
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) drive(1, b1[i], i == 7, i == 2, 0);
        idle(2);
        chk("t6_nwr", nwr - n0, 4);
        chk("t6_m1", mem[1], 16'h5678);
        chk("t6_m3", mem[3], 16'hDEF0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom % 400) == 0;
            in_valid = ($urandom % 4) != 0;
            in_data  = 8'($urandom);
            in_last  = ($urandom % 12) == 0;
            start    = ($urandom % 15) == 0;
            abort    = ($urandom % 50) == 0;
        end
        @(negedge clk);
        rst = 0; in_valid = 0; in_last = 0; start = 0; abort = 0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
